// File: rtl/alu_issue_buffer_if.sv
// alu_issue_buffer_if: operation handshake between upstream, the issue buffer and the ALU
//   upstream side : inValid/inReady handshake, inAluOp, inA, inB, inDest
//   ALU side      : outValid/outReady handshake, aluOp, aIn, bIn, outDest
//   master        : the agent driving operations in and consuming the head
//   slave         : the buffer itself
interface alu_issue_buffer_if;
    logic        inValid;
    logic        inReady;
    logic [3:0]  inAluOp;
    logic [15:0] inA;
    logic [15:0] inB;
    logic [3:0]  inDest;
    logic        outValid;
    logic        outReady;
    logic [3:0]  aluOp;
    logic [15:0] aIn;
    logic [15:0] bIn;
    logic [3:0]  outDest;
    modport master (
        output inValid, inAluOp, inA, inB, inDest, outReady,
        input  inReady, outValid, aluOp, aIn, bIn, outDest
    );
    modport slave (
        input  inValid, inAluOp, inA, inB, inDest, outReady,
        output inReady, outValid, aluOp, aIn, bIn, outDest
    );
endinterface

// File: rtl/alu_issue_buffer.sv
// alu_issue_buffer: 2-entry in-order operation buffer feeding an ALU
//   clk       : clock, all state on rising edge
//   rstN      : synchronous active-low reset
//   flush     : discard all buffered operations
//   bus       : slave side of alu_issue_buffer_if (push/pop handshakes and head fields)
//   count     : occupancy 0..2
//   illegalOp : sticky flag, set once an illegal opcode is accepted
module alu_issue_buffer (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 flush,
    alu_issue_buffer_if.slave    bus,
    output logic [1:0]           count,
    output logic                 illegalOp
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  dest;
    } entry_t;
    state_t state_q;
    entry_t head_q;
    entry_t slot1_q;
    logic   ill_q;
    logic   push;
    logic   pop;
    logic   in_ill;
    entry_t in_e;
    // 1010..1101 are exactly the codes with bit3 set and bits2:1 differing
    assign in_ill = bus.inAluOp[3] & (bus.inAluOp[2] ^ bus.inAluOp[1]);
    assign in_e = '{op: in_ill ? 4'd0 : bus.inAluOp, a: bus.inA, b: bus.inB, dest: bus.inDest};
    assign bus.inReady = rstN && (state_q != FULL);
    assign bus.outValid = (state_q != EMPTY);
    assign push = bus.inValid && bus.inReady;
    assign pop = bus.outValid && bus.outReady;
    assign count = state_q;
    assign illegalOp = ill_q;
    assign bus.aluOp = head_q.op;
    assign bus.aIn = head_q.a;
    assign bus.bIn = head_q.b;
    assign bus.outDest = head_q.dest;
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q <= EMPTY;
            head_q  <= '0;
            slot1_q <= '0;
            ill_q   <= 1'b0;
        end else if (flush) begin
            state_q <= EMPTY;
        end else begin
            if (push && in_ill) ill_q <= 1'b1;
            case (state_q)
                EMPTY: if (push) begin
                    head_q  <= in_e;
                    state_q <= ONE;
                end
                ONE: if (push && pop) begin
                    head_q <= in_e;
                end else if (push) begin
                    slot1_q <= in_e;
                    state_q <= FULL;
                end else if (pop) begin
                    state_q <= EMPTY;
                end
                FULL: if (pop) begin
                    head_q  <= slot1_q;
                    state_q <= ONE;
                end
                default: state_q <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_buffer.sv
// tb_alu_issue_buffer: scoreboard bench for alu_issue_buffer
module tb_alu_issue_buffer;
    logic clk = 1'b0;
    logic rstN;
    logic flush;
    logic [1:0] count;
    logic illegalOp;
    int pass_cnt = 0;
    int total = 0;
    logic [39:0] sbq[$];
    bit mill = 1'b0;

    alu_issue_buffer_if bus ();

    alu_issue_buffer dut (
        .clk(clk), .rstN(rstN), .flush(flush), .bus(bus.slave),
        .count(count), .illegalOp(illegalOp)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] head();
        return {bus.aluOp, bus.aIn, bus.bIn, bus.outDest};
    endfunction

    function automatic bit is_ill(input logic [3:0] op);
        return op inside {4'b1010, 4'b1011, 4'b1100, 4'b1101};
    endfunction

    // drives one cycle of inputs and updates the reference queue at the edge
    task automatic step(input logic rn, fl, iv, input logic [3:0] op,
                        input logic [15:0] a, b, input logic [3:0] d, input logic ordy);
        bit push, pop;
        rstN = rn; flush = fl; bus.inValid = iv; bus.inAluOp = op;
        bus.inA = a; bus.inB = b; bus.inDest = d; bus.outReady = ordy;
        push = rn && !fl && iv && sbq.size() < 2;
        pop = rn && !fl && ordy && sbq.size() != 0;
        @(posedge clk);
        if (!rn) begin
            sbq.delete();
            mill = 1'b0;
        end else if (fl) begin
            sbq.delete();
        end else begin
            if (pop) sbq.delete(0);
            if (push) begin
                sbq.push_back({is_ill(op) ? 4'd0 : op, a, b, d});
                if (is_ill(op)) mill = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0);
        total++; if (bus.inReady !== 1'b0) $display("FAIL rst_inReady got=%b exp=0", bus.inReady); else pass_cnt++;
        step(0, 1, 1, 4'hB, 16'hFFFF, 16'hFFFF, 4'hF, 1);
        total++; if (count !== 2'd0) $display("FAIL rst_count got=%0d exp=0", count); else pass_cnt++;
        total++; if (bus.outValid !== 1'b0) $display("FAIL rst_outValid got=%b exp=0", bus.outValid); else pass_cnt++;
        total++; if (head() !== 40'd0) $display("FAIL rst_head got=%h exp=0", head()); else pass_cnt++;
        total++; if (illegalOp !== 1'b0) $display("FAIL rst_illegal got=%b exp=0", illegalOp); else pass_cnt++;
    endtask

    task automatic test_single_push();
        step(1, 0, 1, 4'h0, 16'h0003, 16'h0004, 4'd5, 0);
        total++; if (bus.outValid !== 1'b1) $display("FAIL single_outValid got=%b exp=1", bus.outValid); else pass_cnt++;
        total++; if (head() !== {4'h0, 16'h0003, 16'h0004, 4'h5}) $display("FAIL single_head got=%h exp=%h", head(), {4'h0, 16'h0003, 16'h0004, 4'h5}); else pass_cnt++;
        total++; if (count !== 2'd1) $display("FAIL single_count got=%0d exp=1", count); else pass_cnt++;
        step(1, 0, 0, 0, 0, 0, 0, 1);
        total++; if (count !== 2'd0) $display("FAIL single_drain got=%0d exp=0", count); else pass_cnt++;
    endtask

    task automatic test_back_pressure();
        step(1, 0, 1, 4'h1, 16'h1111, 16'h0001, 4'd1, 0);
        step(1, 0, 1, 4'h2, 16'h2222, 16'h0002, 4'd2, 0);
        total++; if (count !== 2'd2) $display("FAIL bp_count got=%0d exp=2", count); else pass_cnt++;
        total++; if (bus.inReady !== 1'b0) $display("FAIL bp_inReady got=%b exp=0", bus.inReady); else pass_cnt++;
        step(1, 0, 1, 4'h3, 16'h9999, 16'h0003, 4'd3, 0);
        total++; if (count !== 2'd2) $display("FAIL bp_third got=%0d exp=2", count); else pass_cnt++;
        total++; if (bus.aIn !== 16'h1111) $display("FAIL bp_hold got=%h exp=1111", bus.aIn); else pass_cnt++;
        step(1, 0, 0, 0, 0, 0, 0, 1);
        total++; if (bus.aIn !== 16'h2222) $display("FAIL bp_pop_aIn got=%h exp=2222", bus.aIn); else pass_cnt++;
        total++; if (count !== 2'd1) $display("FAIL bp_pop_count got=%0d exp=1", count); else pass_cnt++;
        total++; if (head() !== sbq[0]) $display("FAIL bp_sb got=%h exp=%h", head(), sbq[0]); else pass_cnt++;
    endtask

    task automatic test_push_pop();
        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 1, 4'h4, 16'h1111, 16'h0, 4'd1, 0);
        step(1, 0, 1, 4'h5, 16'h3333, 16'h0, 4'd3, 1);
        total++; if (count !== 2'd1) $display("FAIL pp_count got=%0d exp=1", count); else pass_cnt++;
        total++; if (bus.aIn !== 16'h3333) $display("FAIL pp_aIn got=%h exp=3333", bus.aIn); else pass_cnt++;
        step(1, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_flush();
        step(1, 0, 1, 4'h6, 16'hAAAA, 16'h1, 4'd6, 0);
        step(1, 0, 1, 4'h7, 16'hBBBB, 16'h2, 4'd7, 0);
        total++; if (count !== 2'd2) $display("FAIL fl_full got=%0d exp=2", count); else pass_cnt++;
        step(1, 1, 1, 4'h8, 16'hCCCC, 16'h3, 4'd8, 0);
        total++; if (count !== 2'd0) $display("FAIL fl_count got=%0d exp=0", count); else pass_cnt++;
        total++; if (bus.outValid !== 1'b0) $display("FAIL fl_outValid got=%b exp=0", bus.outValid); else pass_cnt++;
        total++; if (bus.inReady !== 1'b1) $display("FAIL fl_inReady got=%b exp=1", bus.inReady); else pass_cnt++;
    endtask

    task automatic test_illegal();
        step(1, 0, 0, 4'hB, 16'h1, 16'h1, 4'd1, 0);
        total++; if (illegalOp !== 1'b0) $display("FAIL ill_novalid got=%b exp=0", illegalOp); else pass_cnt++;
        step(1, 1, 1, 4'hC, 16'h1, 16'h1, 4'd1, 0);
        total++; if (illegalOp !== 1'b0) $display("FAIL ill_flush got=%b exp=0", illegalOp); else pass_cnt++;
        for (int op = 0; op < 16; op++) begin
            if (op >= 10 && op <= 13) continue;
            step(1, 0, 1, 4'(op), 16'($urandom), 16'($urandom), 4'(op), 0);
            total++; if (head() !== sbq[0] || bus.aluOp !== 4'(op)) $display("FAIL legal_op%0d got=%h exp=%h", op, head(), sbq[0]); else pass_cnt++;
            step(1, 0, 0, 0, 0, 0, 0, 1);
        end
        total++; if (illegalOp !== 1'b0) $display("FAIL ill_legal got=%b exp=0", illegalOp); else pass_cnt++;
        step(1, 0, 1, 4'b1011, 16'h00FF, 16'h1234, 4'd7, 0);
        total++; if (bus.aluOp !== 4'd0) $display("FAIL ill_op got=%h exp=0", bus.aluOp); else pass_cnt++;
        total++; if ({bus.aIn, bus.bIn, bus.outDest} !== {16'h00FF, 16'h1234, 4'd7}) $display("FAIL ill_fields got=%h exp=00ff12347", {bus.aIn, bus.bIn, bus.outDest}); else pass_cnt++;
        total++; if (illegalOp !== 1'b1) $display("FAIL ill_set got=%b exp=1", illegalOp); else pass_cnt++;
        step(1, 1, 0, 0, 0, 0, 0, 0);
        total++; if (illegalOp !== 1'b1) $display("FAIL ill_sticky got=%b exp=1", illegalOp); else pass_cnt++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(1, $urandom_range(0, 15) == 0, 1'($urandom), 4'($urandom), 16'($urandom),
                 16'($urandom), 4'($urandom), 1'($urandom));
            total++;
            if (int'(count) !== sbq.size() || bus.inReady !== (sbq.size() < 2) || bus.outValid !== (sbq.size() != 0)
                || illegalOp !== mill || (sbq.size() != 0 && head() !== sbq[0]))
                $display("FAIL rnd_%0d cnt=%0d/%0d rdy=%b vld=%b ill=%b/%b head=%h exp=%h", i, count, sbq.size(),
                         bus.inReady, bus.outValid, illegalOp, mill, head(), sbq.size() != 0 ? sbq[0] : 40'd0);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 4'h1, 16'h1234, 16'h5678, 4'd9, 0);
        step(1, 0, 1, 4'hB, 16'h4321, 16'h8765, 4'd3, 0);
        total++; if (count !== 2'd2 || illegalOp !== 1'b1) $display("FAIL rm_full cnt=%0d ill=%b exp=2,1", count, illegalOp); else pass_cnt++;
        step(0, 0, 1, 4'h2, 16'h1, 16'h1, 4'd1, 1);
        total++; if (bus.inReady !== 1'b0) $display("FAIL rm_inReady got=%b exp=0", bus.inReady); else pass_cnt++;
        total++; if (count !== 2'd0 || bus.outValid !== 1'b0) $display("FAIL rm_empty cnt=%0d vld=%b exp=0,0", count, bus.outValid); else pass_cnt++;
        total++; if (head() !== 40'd0) $display("FAIL rm_head got=%h exp=0", head()); else pass_cnt++;
        total++; if (illegalOp !== 1'b0) $display("FAIL rm_illegal got=%b exp=0", illegalOp); else pass_cnt++;
        step(1, 0, 1, 4'h2, 16'hBEEF, 16'hCAFE, 4'd4, 0);
        total++; if (bus.outValid !== 1'b1 || head() !== {4'h2, 16'hBEEF, 16'hCAFE, 4'h4}) $display("FAIL rm_push vld=%b head=%h exp=1,2beefcafe4", bus.outValid, head()); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_back_pressure();
        test_push_pop();
        test_flush();
        test_illegal();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
